// File: rtl/router_pkg.sv
// Shared types and constants for the router register block.
package router_pkg;

    // Packet tracker states
    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StBody,
        StCheck,
        StDone
    } track_state_e;

    localparam int unsigned PARITY_XOR = 0;
    localparam int unsigned PARITY_SUM = 1;

endpackage

// File: rtl/router_hold_buf.sv
// Small circular hold buffer for words that arrive while the downstream FIFO is full.
module router_hold_buf #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned HOLD_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              push,
    input  logic                              pop,
    input  logic [DATA_W-1:0]                 din,
    output logic [DATA_W-1:0]                 dout,
    output logic [$clog2(HOLD_DEPTH+1)-1:0]   count,
    output logic                              full
);

    localparam int unsigned CNT_W = $clog2(HOLD_DEPTH + 1);
    localparam int unsigned PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;

    logic [DATA_W-1:0] mem [HOLD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(HOLD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full buffer is only accepted when a pop frees a slot the same cycle.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && (!full || do_pop);
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(HOLD_DEPTH));

endmodule

// File: rtl/router_reg_gen.sv
// Router register block: header capture, FIFO data path with hold buffer,
// running parity/length tracking and packet status flags.
module router_reg_gen
    import router_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned HOLD_DEPTH  = 2,
    parameter int unsigned PARITY_MODE = 0
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              pkt_valid,
    input  logic                              fifo_full,
    input  logic                              rst_int_reg,
    input  logic                              detect_add,
    input  logic                              ld_state,
    input  logic                              laf_state,
    input  logic                              full_state,
    input  logic                              lfd_state,
    input  logic [DATA_W-1:0]                 data_in,
    output logic [DATA_W-1:0]                 data_out,
    output logic                              data_out_valid,
    output logic                              parity_done,
    output logic                              low_pkt_valid,
    output logic                              err,
    output logic                              len_err,
    output logic                              hold_ovf,
    output logic [$clog2(HOLD_DEPTH+1)-1:0]   hold_count,
    output logic                              hold_full
);

    localparam int unsigned LEN_W = DATA_W - ADDR_W;

    track_state_e      state_q, state_d;
    logic [DATA_W-1:0] header_q, parity_q, parity_d, pbyte_q, hold_dout;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              hold_push, hold_pop, parity_accept;

    function automatic logic [DATA_W-1:0] par_acc(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        if (PARITY_MODE == PARITY_SUM) return a + b;
        return a ^ b;
    endfunction

    // Hold-buffer control; pop only when nothing else claims data_out this cycle
    always_comb begin
        hold_push     = ld_state && fifo_full;
        hold_pop      = laf_state && !fifo_full && (hold_count != '0) && !ld_state && !lfd_state;
        parity_accept = (state_q == StBody) && ld_state && !pkt_valid;
    end

    router_hold_buf #(
        .DATA_W     (DATA_W),
        .HOLD_DEPTH (HOLD_DEPTH)
    ) u_hold_buf (
        .clk    (clk),
        .resetn (resetn),
        .push   (hold_push),
        .pop    (hold_pop),
        .din    (data_in),
        .dout   (hold_dout),
        .count  (hold_count),
        .full   (hold_full)
    );

    // Tracker next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (detect_add && pkt_valid) state_d = StHdr;
            StHdr:   if (lfd_state) state_d = StBody;
            StBody:  if (parity_accept) state_d = StCheck;
            StCheck: state_d = StDone;
            StDone: begin
                if (detect_add && pkt_valid) state_d = StHdr;
                else if (detect_add)         state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Running parity and payload count; DONE also clears so back-to-back packets start clean
    always_comb begin
        parity_d = parity_q;
        cnt_d    = cnt_q;
        if (detect_add && (state_q inside {StIdle, StHdr, StDone})) begin
            parity_d = '0;
        end else if ((state_q == StHdr) && lfd_state) begin
            parity_d = par_acc(parity_q, header_q);
        end else if ((state_q == StBody) && ld_state && pkt_valid && !full_state) begin
            parity_d = par_acc(parity_q, data_in);
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        if (detect_add) cnt_d = '0;
    end

    // Tracker, header, parity, count and parity-byte registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            header_q <= '0;
            parity_q <= '0;
            cnt_q    <= '0;
            pbyte_q  <= '0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
            if (detect_add && pkt_valid) header_q <= data_in;
            if (parity_accept)           pbyte_q  <= data_in;
        end
    end

    // Output word and one-cycle write strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            if (lfd_state) begin
                data_out       <= header_q;
                data_out_valid <= 1'b1;
            end else if (ld_state && !fifo_full) begin
                data_out       <= data_in;
                data_out_valid <= 1'b1;
            end else if (hold_pop) begin
                data_out       <= hold_dout;
                data_out_valid <= 1'b1;
            end
        end
    end

    // Status flags; overflow set beats the detect_add clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_done   <= 1'b0;
            err           <= 1'b0;
            len_err       <= 1'b0;
            hold_ovf      <= 1'b0;
            low_pkt_valid <= 1'b0;
        end else begin
            if (detect_add) begin
                parity_done <= 1'b0;
                err         <= 1'b0;
                len_err     <= 1'b0;
            end else if (state_q == StCheck) begin
                parity_done <= 1'b1;
                err         <= (pbyte_q != parity_q);
                len_err     <= (cnt_q != header_q[DATA_W-1:ADDR_W]);
            end
            if (hold_push && hold_full) hold_ovf <= 1'b1;
            else if (detect_add)        hold_ovf <= 1'b0;
            if (rst_int_reg)                  low_pkt_valid <= 1'b0;
            else if (ld_state && !pkt_valid)  low_pkt_valid <= 1'b1;
        end
    end

endmodule

// File: doc/router_reg_gen.md
ROUTER_REG_GEN -- requirements
Module: router_reg_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning datapath width in bits (minimum 4).
REQ-002 The block SHALL have parameter ADDR_W, default 2, meaning the header low field holding the destination address; header[DATA_W-1:ADDR_W] holds the payload length.
REQ-003 The block SHALL have parameter HOLD_DEPTH, default 2, meaning the number of hold-buffer entries for words arriving while fifo_full is high (power of two, at least 1).
REQ-004 The block SHALL have parameter PARITY_MODE, default 0, meaning 0 = XOR parity and 1 = modulo-2^DATA_W sum parity.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock (all logic on the rising edge).
REQ-006 The block SHALL have port resetn, input, 1 bit, meaning reset: asynchronous, active-low.
REQ-007 The block SHALL have input ports pkt_valid, fifo_full, rst_int_reg, detect_add, ld_state, laf_state, full_state and lfd_state, each 1 bit, carrying router FSM state and handshake flags.
REQ-008 The block SHALL have port data_in, input, DATA_W bits, meaning the incoming packet byte.
REQ-009 The block SHALL have port data_out, output, DATA_W bits, meaning the word to the FIFO; port data_out_valid, output, 1 bit, meaning a one-cycle write strobe for data_out.
REQ-010 The block SHALL have output ports parity_done, low_pkt_valid, err, len_err and hold_ovf, each 1 bit, carrying status.
REQ-011 The block SHALL have port hold_count, output, $clog2(HOLD_DEPTH+1) bits, meaning the hold-buffer occupancy; port hold_full, output, 1 bit, meaning hold_count == HOLD_DEPTH.

Function
REQ-012 The block SHALL capture data_in into the header register when detect_add && pkt_valid.
REQ-013 The block SHALL, on lfd_state, load data_out with the header and pulse data_out_valid the next cycle.
REQ-014 The block SHALL, on ld_state && !fifo_full, forward data_in to data_out with data_out_valid (latency 1), including the parity byte (pkt_valid=0).
REQ-015 The block SHALL, on ld_state && fifo_full, push data_in into the hold buffer; a push when hold_full drops the word and sets sticky hold_ovf.
REQ-016 The block SHALL, on laf_state && !fifo_full && hold_count>0, pop the oldest entry to data_out with data_out_valid; it SHALL preserve FIFO order, and a simultaneous push and pop SHALL keep hold_count unchanged.
REQ-017 The block SHALL set low_pkt_valid on ld_state && !pkt_valid and clear it on rst_int_reg; rst_int_reg SHALL win if both occur together.
REQ-018 The block SHALL run a tracker FSM with states IDLE, HDR, BODY, CHECK and DONE: IDLE->HDR on detect_add&&pkt_valid; HDR->BODY on lfd_state; BODY->CHECK when the parity byte is accepted (ld_state&&!pkt_valid), including when it goes to the hold buffer; CHECK->DONE after one cycle; DONE->HDR on detect_add&&pkt_valid, else DONE->IDLE on detect_add.
REQ-019 The running parity SHALL be cleared in IDLE/HDR on detect_add, then accumulate the header at lfd_state and each payload byte with ld_state&&pkt_valid&&!full_state, per PARITY_MODE.
REQ-020 The payload counter, of width DATA_W-ADDR_W, SHALL increment with each accumulated payload byte, saturate at all-ones and clear on detect_add.
REQ-021 In CHECK, the block SHALL set parity_done, set err = (parity byte != running parity) and set len_err = (count != header length field); these SHALL hold until detect_add.
REQ-022 The block SHALL clear parity_done, err, len_err and hold_ovf on detect_add, and SHALL NOT clear the hold buffer.
REQ-023 The block SHALL ignore lfd_state/ld_state outside HDR/BODY for parity and count but still honour the data path rules above.

Reset
REQ-024 On resetn low, immediately and asynchronously, the block SHALL clear data_out, data_out_valid, parity_done, low_pkt_valid, err, len_err, hold_ovf, hold_count, the FSM (to IDLE), the header, the parity, the counter and the hold pointers.
REQ-025 The block SHALL clear the FSM and all of the above on reset asserted mid-packet, with no residual output after release; the first valid action SHALL be the next detect_add.

Structure
REQ-026 The tracker state enum and the PARITY_XOR/PARITY_SUM constants SHALL reside in shared package router_pkg.
REQ-027 The hold buffer SHALL be sub-module router_hold_buf (parameters DATA_W and HOLD_DEPTH; ports push, pop, din, dout, count and full).

Verification
REQ-028 With defaults, header 0x0D, payload 0x11 0x22 0x33 and parity 0x0D, the bench SHALL see data_out 0x0D,0x11,0x22,0x33,0x0D, then parity_done=1, err=0 and len_err=0.
REQ-029 In the same packet with parity byte 0x0C, the bench SHALL see err=1 in CHECK, with err held until the next detect_add.
REQ-030 With PARITY_MODE=1, header 0x0D, payload 0x11 0x22 0x33 and parity 0x73, the bench SHALL see err=0; with parity 0x0D it SHALL see err=1.
REQ-031 With header 0x0D and only two payload bytes, the bench SHALL see len_err=1; with five payload bytes it SHALL see len_err=1.
REQ-032 With fifo_full high for 3 ld_state bytes at HOLD_DEPTH=2, the bench SHALL see hold_full=1 and hold_ovf=1; laf_state with fifo_full low SHALL pop the first two bytes in order and hold_count SHALL reach 0.
REQ-033 With resetn asserted in BODY with hold_count=1, the bench SHALL see all outputs go to 0 the same cycle, with no data_out_valid after release until a new packet.
